// File: rtl/sdram_responder_pkg.sv
// Shared constants for the SDRAM responder: FSM encodings, minimum read latency
// and the read/write encoding shared with the cache-side FSM.
package sdram_responder_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Array access and the output register account for two cycles of read latency.
  localparam int RD_LAT_MIN = 2;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/sdram_rd_pipe.sv
// Delay line of {valid, last, data} entries between the array read register and Dout.
// DEPTH register stages; DEPTH == 0 is a pure pass-through. Only valid bits are reset.
module sdram_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic         last_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic         last_o,
  output logic [W-1:0] dat_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk ^ rst;
    assign vld_o  = vld_i;
    assign last_o = last_i;
    assign dat_o  = dat_i;
  end else begin : g_regs
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= vld_i;
        for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      last_q[0] <= last_i;
      dat_q[0]  <= dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        last_q[i] <= last_q[i-1];
        dat_q[i]  <= dat_q[i-1];
      end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];
    assign dat_o  = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/sdram_responder.sv
// Strobe-driven SDRAM model: one byte access per rising edge of mstrb_sdram,
// pattern fill after reset, fixed RD_LATENCY read path with block-done pulses.
module sdram_responder
  import sdram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int OFFSET_SIZE = 5,
  parameter int RD_LATENCY  = 3,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_sdram,
  input  logic                  wr_rd_sdram,
  input  logic                  mstrb_sdram,
  input  logic [DATA_WIDTH-1:0] Din_sdram,
  output logic [DATA_WIDTH-1:0] Dout_sdram,
  output logic                  dout_valid_sdram,
  output logic                  busy_sdram,
  output logic                  blk_done_sdram,
  output logic                  err_sdram
);

  function automatic logic [DATA_WIDTH-1:0] fold(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int c = 0; c < ADDR_WIDTH; c += DATA_WIDTH) r ^= DATA_WIDTH'(a >> c);
    return r;
  endfunction

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  mstrb_q, err_q, err_d;
  logic                  s0_vld_q, s0_vld_d, s0_wr_q, s0_wr_d;
  logic [ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
  logic [DATA_WIDTH-1:0] s0_dat_q, s0_dat_d;
  logic                  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_dat_q;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_vld_q, blk_q, blk_d;
  logic                  p_vld, p_last;
  logic [DATA_WIDTH-1:0] p_dat;
  logic                  strobe_edge, in_init, s0_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdat;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign strobe_edge = mstrb_sdram & ~mstrb_q;
  assign in_init     = (state_q == ST_INIT);
  assign s0_last     = &s0_addr_q[OFFSET_SIZE-1:0];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (in_init) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_d = ST_RUN;
    end
    // Strobes during the fill are dropped and only flagged.
    err_d     = err_q | (strobe_edge & in_init);
    s0_vld_d  = strobe_edge & ~in_init;
    s0_wr_d   = s0_vld_d ? wr_rd_sdram   : s0_wr_q;
    s0_addr_d = s0_vld_d ? Address_sdram : s0_addr_q;
    s0_dat_d  = s0_vld_d ? Din_sdram     : s0_dat_q;
    rd_vld_d  = s0_vld_q & (s0_wr_q == RD);
    rd_last_d = s0_last;
    dout_d    = p_vld ? p_dat : dout_q;
    blk_d     = (p_vld & p_last) | (s0_vld_q & (s0_wr_q == WR) & s0_last);
  end

  assign mem_we    = in_init | (s0_vld_q & (s0_wr_q == WR));
  assign mem_waddr = in_init ? init_cnt_q : s0_addr_q;
  assign mem_wdat  = in_init ? fold(init_cnt_q) : s0_dat_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
    rd_dat_q <= mem[s0_addr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
      mstrb_q    <= 1'b0;
      err_q      <= 1'b0;
      s0_vld_q   <= 1'b0;
      s0_wr_q    <= 1'b0;
      s0_addr_q  <= '0;
      s0_dat_q   <= '0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      blk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      mstrb_q    <= mstrb_sdram;
      err_q      <= err_d;
      s0_vld_q   <= s0_vld_d;
      s0_wr_q    <= s0_wr_d;
      s0_addr_q  <= s0_addr_d;
      s0_dat_q   <= s0_dat_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      dout_q     <= dout_d;
      dout_vld_q <= p_vld;
      blk_q      <= blk_d;
    end
  end

  sdram_rd_pipe #(
    .DEPTH (RD_LATENCY - RD_LAT_MIN),
    .W     (DATA_WIDTH)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (rd_vld_q),
    .last_i (rd_last_q),
    .dat_i  (rd_dat_q),
    .vld_o  (p_vld),
    .last_o (p_last),
    .dat_o  (p_dat)
  );

  assign Dout_sdram       = dout_q;
  assign dout_valid_sdram = dout_vld_q;
  assign busy_sdram       = in_init;
  assign blk_done_sdram   = blk_q;
  assign err_sdram        = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus random accesses against
// a per-address byte model with expected events keyed by clock edge number.
module tb_sdram_responder;

  localparam int AW = 16, DW = 8, OS = 5, LAT = 3;
  localparam int NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Address_sdram;
  logic          wr_rd_sdram, mstrb_sdram;
  logic [DW-1:0] Din_sdram, Dout_sdram;
  logic          dout_valid_sdram, busy_sdram, blk_done_sdram, err_sdram;

  sdram_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_SIZE(OS), .RD_LATENCY(LAT), .INIT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .Address_sdram(Address_sdram), .wr_rd_sdram(wr_rd_sdram),
    .mstrb_sdram(mstrb_sdram), .Din_sdram(Din_sdram), .Dout_sdram(Dout_sdram),
    .dout_valid_sdram(dout_valid_sdram), .busy_sdram(busy_sdram),
    .blk_done_sdram(blk_done_sdram), .err_sdram(err_sdram)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model
  logic [DW-1:0] ref_mem [NWORDS];
  bit            exp_vld [int];
  logic [DW-1:0] exp_dat [int];
  bit            exp_blk [int];
  logic [DW-1:0] exp_dout;
  bit            exp_err, in_rst, quiet;
  int            rel_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_reset();
    for (int a = 0; a < NWORDS; a++) ref_mem[a] = DW'((a >> 8) ^ a);
    exp_vld.delete();
    exp_dat.delete();
    exp_blk.delete();
    exp_dout = '0;
    exp_err  = 1'b0;
  endfunction

  task automatic tick();
    bit v;
    @(posedge clk);
    @(negedge clk);
    if (in_rst) begin
      check_eq("rst_valid", dout_valid_sdram, 0);
      check_eq("rst_dout", Dout_sdram, 0);
      check_eq("rst_blk", blk_done_sdram, 0);
      check_eq("rst_busy", busy_sdram, 1);
      check_eq("rst_err", err_sdram, 0);
    end else if (!quiet) begin
      v = exp_vld.exists(cyc);
      if (v) exp_dout = exp_dat[cyc];
      check_eq("dout_valid", dout_valid_sdram, v);
      check_eq("dout", Dout_sdram, exp_dout);
      check_eq("blk_done", blk_done_sdram, exp_blk.exists(cyc));
      check_eq("busy", busy_sdram, (cyc < rel_cyc + NWORDS));
      check_eq("err", err_sdram, exp_err);
    end
  endtask

  // One strobe access: inputs presented now, sampled at the next rising edge.
  task automatic access(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                        input int hold, input int gap);
    int e;
    Address_sdram = a; wr_rd_sdram = wr; Din_sdram = d; mstrb_sdram = 1'b1;
    e = cyc + 1;
    if (e <= rel_cyc + NWORDS) begin
      exp_err = 1'b1;
    end else if (wr) begin
      ref_mem[a] = d;
      if (a[OS-1:0] == '1) exp_blk[e + 1] = 1'b1;
    end else begin
      exp_vld[e + LAT] = 1'b1;
      exp_dat[e + LAT] = ref_mem[a];
      if (a[OS-1:0] == '1) exp_blk[e + LAT] = 1'b1;
    end
    repeat (hold) tick();
    mstrb_sdram = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    rst = 1'b1; mstrb_sdram = 1'b0; wr_rd_sdram = 1'b0;
    Address_sdram = '0; Din_sdram = '0;
    in_rst = 1'b1; quiet = 1'b0; rel_cyc = 0;
    ref_reset();
    repeat (3) tick();
    rst = 1'b0; rel_cyc = cyc; in_rst = 1'b0;

    // Strobe during the fill: dropped, err set and sticky
    repeat (20) tick();
    access(16'h0000, 1'b1, 8'hFF, 1, 2);
    check_eq("init_err", err_sdram, 1);
    quiet = 1'b1;
    while (cyc < rel_cyc + NWORDS - 4) tick();
    quiet = 1'b0;
    repeat (8) tick();

    // Post-init read
    access(16'h1234, 1'b0, 8'h00, 1, 1);
    repeat (4) tick();
    check_eq("t1_dout", Dout_sdram, 8'h26);
    // Read after write
    access(16'h0040, 1'b1, 8'hA5, 1, 1);
    access(16'h0040, 1'b0, 8'h00, 1, 1);
    repeat (4) tick();
    check_eq("t2_dout", Dout_sdram, 8'hA5);
    // Line fill burst
    for (int i = 0; i < 32; i++) access(AW'(16'h5600 + i), 1'b0, 8'h00, 1, 1);
    repeat (4) tick();
    check_eq("t3_last", Dout_sdram, 8'h56 ^ 8'h1F);
    // The dropped INIT write left location 0 at its fill value
    access(16'h0000, 1'b0, 8'h00, 1, 1);
    repeat (4) tick();
    check_eq("t4_dout", Dout_sdram, 8'h00);
    // Held strobe
    access(16'h00FF, 1'b0, 8'h00, 10, 1);
    repeat (4) tick();
    check_eq("t5_dout", Dout_sdram, 8'hFF);

    // Random traffic, biased to a small region to exercise read-after-write
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) != 0) ? AW'(16'h2000 + $urandom_range(0, 63)) : AW'($urandom);
      access(a, 1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
    end
    repeat (5) tick();

    // Reset with two reads in flight
    access(16'h561F, 1'b0, 8'h00, 1, 1);
    access(16'h1234, 1'b0, 8'h00, 1, 0);
    mstrb_sdram = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", dout_valid_sdram, 0);
    check_eq("mid_rst_dout", Dout_sdram, 0);
    check_eq("mid_rst_blk", blk_done_sdram, 0);
    check_eq("mid_rst_busy", busy_sdram, 1);
    in_rst = 1'b1;
    ref_reset();
    repeat (2) tick();
    rst = 1'b0; rel_cyc = cyc; in_rst = 1'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
